// File: rtl/noise_pkg.sv
// noise_pkg: LFSR tap positions, clamp constants, checker state type and sequence helpers
//   shared by the noise source and the noise checker.
package noise_pkg;

    localparam int NOISE_TAP0 = 0;
    localparam int NOISE_TAP1 = 1;
    localparam int NOISE_TAP2 = 3;
    localparam int NOISE_TAP3 = 12;

    localparam logic [15:0] NOISE_CLAMP_IN  = 16'h8000;
    localparam logic [15:0] NOISE_CLAMP_OUT = 16'h8001;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} noise_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[NOISE_TAP0] ^ s[NOISE_TAP1] ^ s[NOISE_TAP2] ^ s[NOISE_TAP3], s[15:1]};
    endfunction

    // 0x8000 is emitted as 0x8001 so the sample is never the most negative value
    function automatic logic [15:0] clamp(input logic [15:0] s);
        return (s == NOISE_CLAMP_IN) ? NOISE_CLAMP_OUT : s;
    endfunction

endpackage

// File: rtl/noise_popcount16.sv
// noise_popcount16: combinational population count of a 16-bit word.
//   data  : word to count
//   count : number of set bits (0..16)
module noise_popcount16 (
    input  logic [15:0] data,
    output logic [4:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) count = count + 5'(data[i]);
    end

endmodule

// File: rtl/noise_checker.sv
// noise_checker: self-synchronising checker for the 16-bit LFSR noise sample stream.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_valid, i_data : sample strobe and signed sample under test
//   o_locked        : checker locked to the sequence
//   o_err           : one-cycle pulse for a mismatching sample while locked
//   o_err_count     : saturating count of o_err pulses
//   o_sample_count  : saturating count of samples checked while locked
//   o_bit_err_count : saturating sum of wrong bits over locked mismatches
//                     (present only when NOISE_CHECKER_BITERR_EN is defined)
module noise_checker
    import noise_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic signed [15:0]  i_data,
    output logic                o_locked,
    output logic                o_err,
    output logic [CNT_W-1:0]    o_err_count,
    output logic [CNT_W-1:0]    o_sample_count
`ifdef NOISE_CHECKER_BITERR_EN
    ,
    output logic [CNT_W-1:0]    o_bit_err_count
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    noise_state_t   state;
    logic [15:0]    ref_state;
    logic [15:0]    expected;
    logic [MW-1:0]  match_cnt;
    logic [LW-1:0]  miss_cnt;
    logic           match;
    logic           seedable;
    logic           miss;
    logic [CNT_W-1:0] err_inc;
    logic [CNT_W-1:0] sample_inc;

    assign expected   = clamp(ref_state);
    assign match      = i_data == expected;
    // 0x0000 locks the LFSR at zero and 0x8001 is ambiguous after clamping
    assign seedable   = (i_data != 16'h0000) && (i_data != NOISE_CLAMP_OUT);
    assign miss       = i_valid && (state == LOCKED) && !match;
    assign err_inc    = (o_err_count == '1) ? o_err_count : o_err_count + 1'b1;
    assign sample_inc = (o_sample_count == '1) ? o_sample_count : o_sample_count + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= HUNT;
            ref_state      <= '0;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            o_locked       <= 1'b0;
            o_err          <= 1'b0;
            o_err_count    <= '0;
            o_sample_count <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                case (state)
                    HUNT: begin
                        if (seedable) begin
                            ref_state <= lfsr_next(i_data);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!match) begin
                            state <= HUNT;
                        end else begin
                            ref_state <= lfsr_next(ref_state);
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                                miss_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // flywheel: the reference never reloads from the input while locked
                        ref_state      <= lfsr_next(ref_state);
                        o_sample_count <= sample_inc;
                        if (match) begin
                            miss_cnt <= '0;
                        end else begin
                            o_err       <= 1'b1;
                            o_err_count <= err_inc;
                            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                                state    <= HUNT;
                                o_locked <= 1'b0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef NOISE_CHECKER_BITERR_EN
    logic [4:0]     pop;
    logic [CNT_W:0] bit_sum;

    noise_popcount16 u_pop (
        .data  (i_data ^ expected),
        .count (pop)
    );

    // one extra bit catches overflow of the multi-bit add so it can saturate
    assign bit_sum = {1'b0, o_bit_err_count} + (CNT_W + 1)'(pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_bit_err_count <= '0;
        else if (miss) o_bit_err_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
`endif

endmodule

// File: tb/tb_noise_checker.sv
// tb_noise_checker: randomized self-checking bench for noise_checker with a behavioural model.
module tb_noise_checker;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_locked;
    logic        o_err;
    logic [15:0] o_err_count;
    logic [15:0] o_sample_count;
`ifdef NOISE_CHECKER_BITERR_EN
    logic [15:0] o_bit_err_count;
`endif

    int compared = 0;
    int mismatched = 0;

    // behavioural model: mode 0 = hunting, 1 = verifying, 2 = locked
    int          m_mode;
    logic [15:0] m_ref;
    int          m_match;
    int          m_miss;
    logic        e_locked;
    logic        e_err;
    logic [15:0] e_errc;
    logic [15:0] e_smp;
    logic [15:0] e_bit;
    logic [15:0] g;

    noise_checker dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_locked       (o_locked),
        .o_err          (o_err),
        .o_err_count    (o_err_count),
        .o_sample_count (o_sample_count)
`ifdef NOISE_CHECKER_BITERR_EN
        ,
        .o_bit_err_count(o_bit_err_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] nx(input logic [15:0] s);
        logic [15:0] fb;
        fb = (s ^ (s >> 1) ^ (s >> 3) ^ (s >> 12)) & 16'h0001;
        return (fb << 15) | (s >> 1);
    endfunction

    function automatic logic [15:0] prv(input logic [15:0] s);
        logic [15:0] b;
        b = ((s >> 15) ^ s ^ (s >> 2) ^ (s >> 11)) & 16'h0001;
        return ((s << 1) & 16'hFFFE) | b;
    endfunction

    function automatic logic [15:0] clampf(input logic [15:0] s);
        return (s == 16'h8000) ? 16'h8001 : s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ref = 0; m_match = 0; m_miss = 0;
        e_locked = 0; e_err = 0; e_errc = 0; e_smp = 0; e_bit = 0;
    endtask

    task automatic model(input logic v, input logic [15:0] d);
        int sum;
        e_err = 0;
        if (!v) return;
        if (m_mode == 0) begin
            if (d != 16'h0000 && d != 16'h8001) begin
                m_ref = nx(d); m_mode = 1; m_match = 0;
            end
        end else if (m_mode == 1) begin
            if (d == clampf(m_ref)) begin
                m_ref = nx(m_ref);
                m_match++;
                if (m_match == 16) begin m_mode = 2; m_miss = 0; e_locked = 1; end
            end else begin
                m_mode = 0;
            end
        end else begin
            if (e_smp != 16'hFFFF) e_smp++;
            if (d == clampf(m_ref)) begin
                m_miss = 0;
            end else begin
                e_err = 1;
                if (e_errc != 16'hFFFF) e_errc++;
                sum = int'(e_bit) + $countones(d ^ clampf(m_ref));
                e_bit = (sum > 65535) ? 16'hFFFF : 16'(sum);
                m_miss++;
                if (m_miss == 4) begin m_mode = 0; e_locked = 0; end
            end
            m_ref = nx(m_ref);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        i_valid = v; i_data = d;
        model(v, d);
        @(posedge i_clk); #1;
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_valid = 1; i_data = 16'h1234;
        model_reset();
        @(posedge i_clk); #1;
        i_rst_n = 1; i_valid = 0;
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();
        compared++;
        if ({o_locked, o_err, o_err_count, o_sample_count} !== 34'h0) begin
            mismatched++;
            $display("FAIL reset_state: got %h want 0", {o_locked, o_err, o_err_count, o_sample_count});
        end
    endtask

    task automatic test_lock();
        g = 16'hDEAD;
        for (int i = 0; i < 17; i++) begin
            step(1, clampf(g)); g = nx(g);
            compared++;
            if (o_locked !== (i == 16)) begin
                mismatched++;
                $display("FAIL lock_rise[%0d]: got %b want %b", i, o_locked, i == 16);
            end
        end
        compared++;
        if ({o_err, o_err_count, o_sample_count} !== 33'h0) begin
            mismatched++;
            $display("FAIL lock_counts: got %h want 0", {o_err, o_err_count, o_sample_count});
        end
    endtask

    task automatic test_single_err();
        step(1, clampf(g) ^ 16'h0001); g = nx(g);
        compared++;
        if ({o_locked, o_err, o_err_count, o_sample_count} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
            mismatched++;
            $display("FAIL single_err: got %b %b %0d %0d want 1 1 1 1", o_locked, o_err, o_err_count, o_sample_count);
        end
`ifdef NOISE_CHECKER_BITERR_EN
        compared++;
        if (o_bit_err_count !== 16'd1) begin
            mismatched++;
            $display("FAIL bit_err_count: got %0d want 1", o_bit_err_count);
        end
`endif
        step(1, clampf(g)); g = nx(g);
        compared++;
        if ({o_locked, o_err, o_err_count, o_sample_count} !== {1'b1, 1'b0, 16'd1, 16'd2}) begin
            mismatched++;
            $display("FAIL flywheel: got %b %b %0d %0d want 1 0 1 2", o_locked, o_err, o_err_count, o_sample_count);
        end
    endtask

    task automatic test_loss_relock();
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h1234); g = nx(g);
            compared++;
            if ({o_locked, o_err, o_err_count} !== {i < 3, 1'b1, 16'(2 + i)}) begin
                mismatched++;
                $display("FAIL loss[%0d]: got %b %b %0d want %b 1 %0d", i, o_locked, o_err, o_err_count, i < 3, 2 + i);
            end
        end
        for (int i = 0; i < 17; i++) begin
            step(1, clampf(g)); g = nx(g);
            compared++;
            if ({o_locked, o_err, o_err_count} !== {i == 16, 1'b0, 16'd5}) begin
                mismatched++;
                $display("FAIL relock[%0d]: got %b %b %0d want %b 0 5", i, o_locked, o_err, o_err_count, i == 16);
            end
        end
    endtask

    task automatic test_gaps();
        int accepted = 0;
        logic v;
        do_reset();
        do g = 16'($urandom); while (g == 16'h0000 || g == 16'h8000 || g == 16'h8001);
        for (int i = 0; i < 240; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                step(1, clampf(g)); g = nx(g); accepted++;
            end else begin
                step(0, 16'($urandom));
            end
            compared++;
            if ({o_locked, o_err, o_err_count, o_sample_count} !== {e_locked, e_err, e_errc, e_smp}) begin
                mismatched++;
                $display("FAIL gaps[%0d]: got %b %b %0d %0d want %b %b %0d %0d", i, o_locked, o_err,
                         o_err_count, o_sample_count, e_locked, e_err, e_errc, e_smp);
            end
        end
        compared++;
        if (o_sample_count !== 16'((accepted > 17) ? accepted - 17 : 0)) begin
            mismatched++;
            $display("FAIL gap_samples: got %0d want %0d", o_sample_count, accepted - 17);
        end
    endtask

    task automatic test_unseedable();
        do_reset();
        step(1, 16'h0000);
        step(1, 16'h8001);
        step(1, 16'h0000);
        step(1, 16'h8001);
        g = 16'hACE1;
        for (int i = 0; i < 17; i++) begin
            step(1, clampf(g)); g = nx(g);
            compared++;
            if (o_locked !== (i == 16)) begin
                mismatched++;
                $display("FAIL unseedable[%0d]: got %b want %b", i, o_locked, i == 16);
            end
        end
    endtask

    task automatic test_clamp(input logic raw);
        do_reset();
        g = 16'h0001;
        for (int i = 0; i < 20; i++) g = prv(g);
        for (int i = 0; i < 21; i++) begin step(1, clampf(g)); g = nx(g); end
        compared++;
        if ({o_locked, o_err} !== 2'b10) begin
            mismatched++;
            $display("FAIL clamp_pre: got %b %b want 1 0", o_locked, o_err);
        end
        step(1, raw ? 16'h8000 : 16'h8001); g = nx(g);
        compared++;
        if ({o_err, o_err_count} !== {raw, 16'(raw)}) begin
            mismatched++;
            $display("FAIL clamp_%0d: got %b %0d want %b %0d", raw, o_err, o_err_count, raw, raw);
        end
        step(1, clampf(g)); g = nx(g);
        compared++;
        if ({o_locked, o_err, o_err_count, o_sample_count} !== {e_locked, e_err, e_errc, e_smp}) begin
            mismatched++;
            $display("FAIL clamp_post: got %b %b %0d %0d want %b %b %0d %0d", o_locked, o_err,
                     o_err_count, o_sample_count, e_locked, e_err, e_errc, e_smp);
        end
    endtask

    task automatic test_midlock_reset();
        step(1, 16'h1111); g = nx(g);
        i_rst_n = 0; i_valid = 1; i_data = clampf(g); g = nx(g);
        model_reset();
        @(posedge i_clk); #1;
        i_rst_n = 1;
        compared++;
        if ({o_locked, o_err, o_err_count, o_sample_count} !== 34'h0) begin
            mismatched++;
            $display("FAIL midlock_reset: got %h want 0", {o_locked, o_err, o_err_count, o_sample_count});
        end
        for (int i = 0; i < 17; i++) begin
            step(1, clampf(g)); g = nx(g);
            compared++;
            if ({o_locked, o_err_count} !== {i == 16, 16'd0}) begin
                mismatched++;
                $display("FAIL reacquire[%0d]: got %b %0d want %b 0", i, o_locked, o_err_count, i == 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_loss_relock();
        test_gaps();
        test_unseedable();
        test_clamp(1'b0);
        test_clamp(1'b1);
        test_midlock_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noise_checker.md
Name: noise_checker

Overview:
- Receive-side checker for the white-noise sample stream produced by the team's 16-bit LFSR noise source.
- Self-synchronises to an incoming stream of signed 16-bit samples, verifies every later sample against its own free-running reference LFSR, and reports lock status and error counts.
- Sits at the sink end of the synth sample path, after any capture or transport logic; used in loopback self-test and bring-up.

Parameters:
- LOCK_CNT, 16, consecutive matching samples after seeding required to declare lock (>=1)
- LOSS_CNT, 4, consecutive mismatching samples while locked that drop lock (>=1)
- CNT_W, 16, width of saturating error and sample counters

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  i_data holds a sample this cycle; the stream may stall
- i_data  input  16  signed sample under test
- o_locked  output  1  checker is locked to the sequence
- o_err  output  1  one-cycle pulse: the accepted sample mismatched while in LOCKED
- o_err_count  output  CNT_W  saturating count of o_err pulses
- o_sample_count  output  CNT_W  saturating count of samples checked while in LOCKED

Behaviour:
- Interface: one clock, i_clk; reset is synchronous, active-low, i_rst_n.
- Sequence definition: the sample word is the LFSR state, bit 15 = MSB.
  - next = {fb, s[15:1]}, where fb = s[0]^s[1]^s[3]^s[12].
  - Emitted sample = state, except state 0x8000 is emitted as 0x8001 (clamp).
- Reference state ref[15:0] is advanced only on accepted samples (i_valid=1); no activity when i_valid=0.
- Reset (any cycle, including mid-lock):
  - next edge forces state HUNT, ref=0, all counters=0, o_locked=0, o_err=0.
- FSM states:
  - HUNT
    - On a valid sample not equal to 0x0000 or 0x8001 (both unseedable): ref <= next(i_data); go to VERIFY with match count 0.
    - On an unseedable sample: stay in HUNT.
  - VERIFY
    - Per valid sample, compare i_data with clamp(ref).
    - Match: ref <= next(ref), match count +1. The LOCK_CNT-th match goes to LOCKED.
    - Mismatch: go to HUNT (that sample is discarded, not used as a seed).
  - LOCKED (flywheel)
    - ref always advances from its own value, never from i_data.
    - Match: clears the consecutive-miss count; o_sample_count +1.
    - Mismatch: o_err=1 for one cycle, o_err_count +1, miss count +1, o_sample_count +1.
    - The LOSS_CNT-th consecutive miss goes to HUNT.
- Output timing: all outputs registered; latency 1 cycle from the accepting edge.
  - o_locked rises the cycle after the LOCK_CNT-th matching sample.
  - o_locked falls the cycle after the LOSS_CNT-th miss; the o_err for that miss is still pulsed.
- Counters: saturate at all-ones; never wrap. They are not cleared on loss of lock, only by reset.
- Clamp boundary: when ref==0x8000, expected is 0x8001. Received 0x8000 is a mismatch.

Optional Feature:
- Macro NOISE_CHECKER_BITERR_EN.
- Defined:
  - Adds output o_bit_err_count [CNT_W-1:0], a saturating sum of popcount(i_data ^ clamp(ref)) over mismatching samples in LOCKED.
  - Updated in the same cycle as o_err_count; saturates instead of overflowing on a multi-bit add.
  - Reset to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package noise_pkg:
  - tap constants (0,1,3,12)
  - NOISE_CLAMP_IN=16'h8000, NOISE_CLAMP_OUT=16'h8001
  - state typedef {HUNT, VERIFY, LOCKED}
  - functions lfsr_next(16b) and clamp(16b), shared with the noise source
- Sub-module noise_popcount16 (combinational 16-bit popcount to 5 bits), instantiated only under NOISE_CHECKER_BITERR_EN.

Test Plan:
- Reset, then stream seeded 0xDEAD (next 0xEF56, ...) with i_valid=1 and LOCK_CNT=16 -> o_locked=1 exactly 1 cycle after the 17th sample (seed + 16 matches); o_err_count=0.
- Locked, corrupt one sample (flip bit 0) -> o_err pulse of 1 cycle; o_err_count=1; o_locked stays 1; the next sample matches without error (flywheel); with BITERR_EN, o_bit_err_count=1.
- Locked, replace 4 consecutive samples with 0x1234 -> 4 o_err pulses, o_locked=0 one cycle after the 4th; clean stream resumes -> relock after 1+16 samples.
- Random i_valid gaps (50% duty) on a clean stream -> lock reached after 17 accepted samples; no errors; o_sample_count equals the number of accepted samples while locked.
- Seeds of 0x0000 and 0x8001 in HUNT -> remain HUNT; stream passing through state 0x8000 while locked -> received 0x8001 matches, received 0x8000 flags o_err.
- Assert i_rst_n=0 for one cycle while locked -> next edge o_locked=0 and counters=0; lock is reacquired normally afterwards.
